dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter MAX_HOLD, default 8, maximum consecutive grants to one locked master while the other requests (range 1..255).
REQ-004 SHALL use reset rst, synchronous, active-low, and clock clk.
REQ-005 Ports, in order:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- mN_req  in  1  master N (N=0 CPU, N=1 debug/DMA) request; held with its command until granted.
- mN_we  in  1  master N write enable.
- mN_lock  in  1  master N asks to keep the grant on the next cycle.
- mN_addr  in  ADDR_W  master N address.
- mN_wdata  in  DATA_W  master N write data.
- mN_gnt  out  1  master N transfer accepted this cycle.
- mN_rvalid  out  1  master N read data valid.
- mN_rdata  out  DATA_W  master N read data.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address.

Function
REQ-006 SHALL accept a transfer in any cycle where mN_req and mN_gnt are both 1; at most one gnt SHALL be high per cycle.
REQ-007 gnt SHALL be combinational from req and registered state; mem_addr/mem_wdata SHALL mux the granted master's command combinationally, and are 0 when none is granted.
REQ-008 mem_we SHALL equal granted master's mN_we in the transfer cycle, else 0.
REQ-009 For a read transfer in cycle t, mN_rvalid SHALL be 1 in cycle t+1 only, with mN_rdata = mem_rdata; the other master's rvalid SHALL be 0.
REQ-010 mN_rdata SHALL be 0 when mN_rvalid is 0.
REQ-011 Arbitration: FSM states IDLE, OWN0, OWN1. When only one master requests, it is granted.
REQ-012 With both requesting and no active lock, SHALL grant the master not granted last (round-robin pointer, updated on every transfer).
REQ-013 A transfer with mN_lock=1 SHALL move FSM to OWNN; in OWNN master N has priority while it requests.
REQ-014 SHALL count consecutive locked grants in OWNN while the other master requests; on reaching MAX_HOLD the next cycle SHALL grant the other master regardless of lock, and counter SHALL clear.
REQ-015 OWNN SHALL return to IDLE when master N's transfer has mN_lock=0 or master N drops req; counter SHALL clear on any state change.
REQ-016 Counter SHALL not increment when the other master is not requesting (no forced switch without contention).
REQ-017 Back-to-back transfers every cycle SHALL be supported with no bubble; read/write interleaving SHALL not stall.

Reset
REQ-018 On rst=0 at a clock edge: FSM=IDLE, pointer favours m0, hold counter=0, rvalid pipeline cleared.
REQ-019 During reset all gnt, rvalid, mem_we SHALL be 0 combinationally; a read accepted in the cycle before reset asserts SHALL NOT produce rvalid.

Structure
REQ-020 State enum (IDLE/OWN0/OWN1) and master index constants SHALL live in shared package mips_pkg.
REQ-021 One sub-module rr_pick2 (2-way round-robin select from req vector and pointer) is natural; remainder flat.

Verification
REQ-022 m0 read 0x10 alone, mem_rdata=0xDEADBEEF next cycle -> m0_gnt=1 in t, m0_rvalid=1, m0_rdata=0xDEADBEEF in t+1, m1_rvalid=0.
REQ-023 Both req continuously, no lock -> grants alternate m0,m1,m0,m1 starting with m0 after reset.
REQ-024 m1 write 0x20/0x55 with m1_lock=1 held, m0 requesting, MAX_HOLD=3 -> m1 granted 3 cycles, m0 granted 4th cycle, mem_we=1 only on m1 cycles.
REQ-025 m0 locked, m1 idle for 20 cycles -> m0 granted all 20, no forced switch.
REQ-026 rst=0 asserted one cycle after m1 read accepted -> m1_rvalid stays 0, FSM IDLE, next contended grant goes to m0.
REQ-027 Alternating read/write every cycle from both masters -> every read's rvalid/rdata routed to its issuing master exactly one cycle later.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared arbitration types and constants for the data-memory port arbiter.
// Master 0 is the CPU and master 1 is the debug/DMA port.
package mips_pkg;

  // Arbiter FSM states. The state names the master that currently owns the port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Master indices into the packed request/grant vectors.
  localparam int MASTER_CPU  = 0;
  localparam int MASTER_DBG  = 1;
  localparam int NUM_MASTERS = 2;

  // The hold counter is 8 bits wide because MAX_HOLD is limited to 1..255.
  localparam int HOLD_W = 8;

  // Returns the ownership state that corresponds to a master index.
  function automatic arb_state_t own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector. When both masters request, the master named
// by ptr wins; otherwise the single requester (if any) wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt[ptr] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with round-robin fairness, bus locking and a
// bounded hold, so a locked master cannot starve the other one.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] we;
  logic [NUM_MASTERS-1:0] lock;
  logic [NUM_MASTERS-1:0] gnt;
  logic [NUM_MASTERS-1:0] rr_gnt;
  logic [ADDR_W-1:0]      addr  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata [NUM_MASTERS];

  arb_state_t             state_reg, state_next;
  logic                   ptr_reg, ptr_next;
  logic [HOLD_W-1:0]      cnt_reg, cnt_next;
  logic [NUM_MASTERS-1:0] rd_reg, rd_next;

  logic                   rvalid_v [NUM_MASTERS];
  logic [DATA_W-1:0]      rdata_v  [NUM_MASTERS];

  logic own;
  logic win;
  logic xfer;

  assign req[MASTER_CPU]   = m0_req;
  assign req[MASTER_DBG]   = m1_req;
  assign we[MASTER_CPU]    = m0_we;
  assign we[MASTER_DBG]    = m1_we;
  assign lock[MASTER_CPU]  = m0_lock;
  assign lock[MASTER_DBG]  = m1_lock;
  assign addr[MASTER_CPU]  = m0_addr;
  assign addr[MASTER_DBG]  = m1_addr;
  assign wdata[MASTER_CPU] = m0_wdata;
  assign wdata[MASTER_DBG] = m1_wdata;

  assign own  = (state_reg == OWN1);
  assign xfer = |gnt;
  assign win  = gnt[MASTER_DBG];

  rr_pick2 u_pick (
    .req (req),
    .ptr (ptr_reg),
    .gnt (rr_gnt)
  );

  // Grant: the owner keeps priority until its hold budget is spent while the
  // other master is waiting; with no live owner, fall back to round-robin.
  always_comb begin
    gnt = '0;
    if (rst) begin
      if (state_reg != IDLE && req[own]) begin
        if (req[~own] && cnt_reg >= HOLD_LIM) begin
          gnt[~own] = 1'b1;
        end else begin
          gnt[own] = 1'b1;
        end
      end else begin
        gnt = rr_gnt;
      end
    end
  end

  // Next state, round-robin pointer and hold counter.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    rd_next    = gnt & ~we;

    if (xfer) begin
      ptr_next   = ~win;
      state_next = lock[win] ? own_state(win) : IDLE;
    end else if (state_reg != IDLE && !req[own]) begin
      state_next = IDLE;
    end

    if (state_next != state_reg) begin
      cnt_next = '0;
    end

    // The locked grant that takes ownership counts toward the hold budget,
    // so MAX_HOLD is the total number of back-to-back grants under contention.
    if (xfer && lock[win] && req[~win] && cnt_next != '1) begin
      cnt_next = cnt_next + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      cnt_reg   <= '0;
      rd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      rd_reg    <= rd_next;
    end
  end

  // Read return: masking with rst suppresses data for a read accepted just
  // before reset asserts.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_ret
      assign rvalid_v[gi] = rd_reg[gi] & rst;
      assign rdata_v[gi]  = rvalid_v[gi] ? mem_rdata : '0;
    end
  endgenerate

  assign m0_gnt    = gnt[MASTER_CPU];
  assign m1_gnt    = gnt[MASTER_DBG];
  assign m0_rvalid = rvalid_v[MASTER_CPU];
  assign m1_rvalid = rvalid_v[MASTER_DBG];
  assign m0_rdata  = rdata_v[MASTER_CPU];
  assign m1_rdata  = rdata_v[MASTER_DBG];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[MASTER_CPU]) begin
      mem_we    = we[MASTER_CPU];
      mem_addr  = addr[MASTER_CPU];
      mem_wdata = wdata[MASTER_CPU];
    end else if (gnt[MASTER_DBG]) begin
      mem_we    = we[MASTER_DBG];
      mem_addr  = addr[MASTER_DBG];
      mem_wdata = wdata[MASTER_DBG];
    end
  end

endmodule
